fifo_wr_arb_ctrl: RTL and testbench

FIFO_WR_ARB_CTRL -- requirements
Module: fifo_wr_arb_ctrl

---
 rtl/fifo_wr_arb_ctrl.sv | 148 ++++++++++++++
 tb/tb_fifo_wr_arb_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb_ctrl.sv
// FIFO controller: round-robin arbitration of two write producers into an external RAM,
// registered read/write pointers, combinational status and sticky overflow/underflow flags.
module fifo_wr_arb_ctrl #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_req0,
    input  logic                wr_req1,
    input  logic [DATASIZE-1:0] wr_data0,
    input  logic [DATASIZE-1:0] wr_data1,
    output logic                wr_gnt0,
    output logic                wr_gnt1,
    input  logic                rd_en,
    output logic [DATASIZE-1:0] rd_data,
    input  logic                clr_err,
    output logic                full,
    output logic                empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow,
    output logic                mem_wr_en,
    output logic                mem_wfull,
    output logic [ADDRSIZE-1:0] mem_wr_addr,
    output logic [ADDRSIZE-1:0] mem_rd_addr,
    output logic [DATASIZE-1:0] mem_wr_data,
    input  logic [DATASIZE-1:0] mem_rd_data
);

    localparam logic [ADDRSIZE:0] PTR_ONE = {{ADDRSIZE{1'b0}}, 1'b1};

    logic [ADDRSIZE:0] wptr_q, wptr_d;
    logic [ADDRSIZE:0] rptr_q, rptr_d;
    logic              prio_q, prio_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              full_s, empty_s, req_any_s, rd_acc_s;
    logic              gnt0_s, gnt1_s;

    // Extra pointer MSB separates the wrapped-full case from empty
    assign empty_s   = (wptr_q == rptr_q);
    assign full_s    = (wptr_q[ADDRSIZE] != rptr_q[ADDRSIZE]) &&
                       (wptr_q[ADDRSIZE-1:0] == rptr_q[ADDRSIZE-1:0]);
    assign req_any_s = wr_req0 | wr_req1;
    assign rd_acc_s  = rd_en & ~empty_s;

    // Round-robin grant selection; nothing is granted while reset is applied
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!rst_n || full_s) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case ({wr_req1, wr_req0})
                2'b01: gnt0_s = 1'b1;
                2'b10: gnt1_s = 1'b1;
                2'b11: begin
                    gnt0_s = ~prio_q;
                    gnt1_s = prio_q;
                end
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
    end

    // Next-state for pointers, arbitration priority and sticky error flags
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        prio_d      = prio_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (gnt0_s || gnt1_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end

        if (rd_acc_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end

        if (gnt0_s) begin
            prio_d = 1'b1;
        end else if (gnt1_s) begin
            prio_d = 1'b0;
        end else begin
            prio_d = prio_q;
        end

        // A new error event wins over a clear in the same cycle
        if (req_any_s && full_s) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (rd_en && empty_s) begin
            underflow_d = 1'b1;
        end else if (clr_err) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= {(ADDRSIZE+1){1'b0}};
            rptr_q      <= {(ADDRSIZE+1){1'b0}};
            prio_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            prio_q      <= prio_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign wr_gnt0     = gnt0_s;
    assign wr_gnt1     = gnt1_s;
    assign mem_wr_en   = gnt0_s | gnt1_s;
    assign mem_wr_data = gnt1_s ? wr_data1 : wr_data0;
    assign mem_wfull   = full_s;
    assign mem_wr_addr = wptr_q[ADDRSIZE-1:0];
    assign mem_rd_addr = rptr_q[ADDRSIZE-1:0];
    assign rd_data     = mem_rd_data;
    assign full        = full_s;
    assign empty       = empty_s;
    assign count       = wptr_q - rptr_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Directed and random checks of fifo_wr_arb_ctrl against a queue-based reference model
// with a behavioural RAM attached to the memory ports.
module tb_fifo_wr_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_req0 = 1'b0, wr_req1 = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
    logic [7:0] wr_data0 = 8'h00, wr_data1 = 8'h00;
    logic       wr_gnt0, wr_gnt1, full, empty, overflow, underflow, mem_wr_en, mem_wfull;
    logic [7:0] rd_data, mem_wr_data, mem_rd_data, count;
    logic [6:0] mem_wr_addr, mem_rd_addr;

    logic [7:0] ram [0:127];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_q [$];
    logic [7:0] m_wptr = 8'd0, m_rptr = 8'd0;
    logic       m_prio = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

    logic       og0, og1;
    logic [7:0] owd;
    logic [6:0] owa;

    fifo_wr_arb_ctrl #(.DATASIZE(8), .ADDRSIZE(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req0(wr_req0), .wr_req1(wr_req1),
        .wr_data0(wr_data0), .wr_data1(wr_data1),
        .wr_gnt0(wr_gnt0), .wr_gnt1(wr_gnt1),
        .rd_en(rd_en), .rd_data(rd_data), .clr_err(clr_err),
        .full(full), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow),
        .mem_wr_en(mem_wr_en), .mem_wfull(mem_wfull),
        .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, combinational read
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
    end
    assign mem_rd_data = ram[mem_rd_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, compare against the model, step the model, pass the edge
    task automatic cyc(input logic r0, input logic [7:0] d0, input logic r1, input logic [7:0] d1,
                       input logic rd, input logic clr,
                       output logic g0_o, output logic g1_o, output logic [7:0] wd_o,
                       output logic [6:0] wa_o);
        logic full_e, empty_e, g0, g1;
        @(negedge clk);
        wr_req0 = r0; wr_data0 = d0; wr_req1 = r1; wr_data1 = d1; rd_en = rd; clr_err = clr;
        #1;
        full_e  = (m_q.size() == 128);
        empty_e = (m_q.size() == 0);
        g0 = 1'b0;
        g1 = 1'b0;
        if (!full_e) begin
            if (r0 && r1) begin
                if (m_prio) g1 = 1'b1; else g0 = 1'b1;
            end else if (r0) g0 = 1'b1;
            else if (r1) g1 = 1'b1;
        end
        check("gnt0", wr_gnt0, g0);
        check("gnt1", wr_gnt1, g1);
        check("mem_wr_en", mem_wr_en, g0 | g1);
        check("mem_wr_data", mem_wr_data, g1 ? d1 : d0);
        check("full", full, full_e);
        check("mem_wfull", mem_wfull, full_e);
        check("empty", empty, empty_e);
        check("count", count, m_q.size());
        check("overflow", overflow, m_ovf);
        check("underflow", underflow, m_udf);
        check("mem_wr_addr", mem_wr_addr, m_wptr[6:0]);
        check("mem_rd_addr", mem_rd_addr, m_rptr[6:0]);
        if (!empty_e) check("rd_data", rd_data, m_q[0]);
        g0_o = wr_gnt0; g1_o = wr_gnt1; wd_o = mem_wr_data; wa_o = mem_wr_addr;

        m_ovf = ((r0 | r1) & full_e) | (m_ovf & ~clr);
        m_udf = (rd & empty_e) | (m_udf & ~clr);
        if (rd && !empty_e) begin
            void'(m_q.pop_front());
            m_rptr = m_rptr + 8'd1;
        end
        if (g0 || g1) begin
            m_q.push_back(g1 ? d1 : d0);
            m_wptr = m_wptr + 8'd1;
            m_prio = g0;
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle with requests active and check the asynchronous response
    task automatic pulse_reset();
        @(negedge clk);
        wr_req0 = 1'b1; wr_req1 = 1'b1; rd_en = 1'b1; clr_err = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_gnt0", wr_gnt0, 0);
        check("rst_gnt1", wr_gnt1, 0);
        check("rst_mem_wr_en", mem_wr_en, 0);
        check("rst_overflow", overflow, 0);
        check("rst_underflow", underflow, 0);
        check("rst_wr_addr", mem_wr_addr, 0);
        m_q.delete();
        m_wptr = 8'd0; m_rptr = 8'd0; m_prio = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wr_req0 = 1'b0; wr_req1 = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        pulse_reset();

        // Producer 0 alone for three cycles
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 8'h00, 1'b0, 1'b0, og0, og1, owd, owa);
            check("t1_gnt0", og0, 1);
            check("t1_addr", owa, i);
        end
        check("t1_count", count, 3);
        check("t1_empty", empty, 0);
        check("t1_rd_data", rd_data, 8'hA0);

        // Both producers continuously: grants alternate starting with producer 0
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'h10 + 8'(i), 1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, og0, og1, owd, owa);
            check("alt_gnt0", og0, (i % 2) == 0);
            check("alt_gnt1", og1, (i % 2) == 1);
            check("alt_wdata", owd, ((i % 2) == 0) ? 8'h10 + i : 8'h20 + i);
        end

        // Fill to 128, then overflow and clear
        pulse_reset();
        for (int i = 0; i < 128; i++)
            cyc(1'b1, 8'(i * 3), 1'b0, 8'h00, 1'b0, 1'b0, og0, og1, owd, owa);
        check("fill_full", full, 1);
        check("fill_count", count, 128);
        cyc(1'b0, 8'h00, 1'b1, 8'hEE, 1'b0, 1'b0, og0, og1, owd, owa);
        check("ovf_gnt1", og1, 0);
        check("ovf_flag", overflow, 1);
        check("ovf_wr_addr", mem_wr_addr, 0);
        check("ovf_count", count, 128);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, og0, og1, owd, owa);
        check("ovf_clr", overflow, 0);

        // Full with simultaneous write and read: only the read goes through, then write wraps
        cyc(1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0, og0, og1, owd, owa);
        check("fullrw_gnt0", og0, 0);
        check("fullrw_count", count, 127);
        cyc(1'b1, 8'h56, 1'b0, 8'h00, 1'b0, 1'b0, og0, og1, owd, owa);
        check("wrap_gnt0", og0, 1);
        check("wrap_addr", owa, 0);
        check("wrap_count", count, 128);

        // Empty with simultaneous write and read: only the write goes through
        pulse_reset();
        cyc(1'b0, 8'h00, 1'b1, 8'h77, 1'b1, 1'b0, og0, og1, owd, owa);
        check("emptyrw_gnt1", og1, 1);
        check("emptyrw_udf", underflow, 1);
        check("emptyrw_count", count, 1);
        check("emptyrw_rd_data", rd_data, 8'h77);

        // Reset while holding 50 words
        pulse_reset();
        for (int i = 0; i < 50; i++)
            cyc(1'b0, 8'h00, 1'b1, 8'(i + 7), 1'b0, 1'b0, og0, og1, owd, owa);
        check("pre_rst_count", count, 50);
        pulse_reset();

        // Random traffic: fill-biased half, then drain-biased half
        for (int i = 0; i < 1000; i++) begin
            int th;
            th = (i < 500) ? 30 : 90;
            cyc(1'($urandom_range(1)), 8'($urandom_range(255)),
                1'($urandom_range(1)), 8'($urandom_range(255)),
                1'($urandom_range(99) < th), 1'($urandom_range(99) < 5),
                og0, og1, owd, owa);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
